scan_mux: RTL and testbench
===========================

# scan_mux

Parametrised, registered N-to-1 channel multiplexer, the successor to the fixed 8:1 1-bit mux.

- Generalises channel count and data width.
- Adds an auto-scan mode: the block cycles through a mask of enabled channels, dwelling a fixed number of cycles on each.
- Sits between a bank of sampled sources (switches, sensors, counters) and a single display or serial consumer that needs one channel at a time plus the channel index.

## Interface
Parameters:
- `WIDTH`, 1: data bits per channel.
- `CHANNELS`, 8: number of input channels, ≥2.
- `DWELL`, 4: cycles spent on each enabled channel in scan mode, ≥1.
- `SEL_W`, `$clog2(CHANNELS)`: derived localparam, not overridable.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in`, in, `CHANNELS*WIDTH`: channel *i* occupies `in[i*WIDTH +: WIDTH]`.
- `sel`, in, `SEL_W`: manual channel select.
- `mode`, in, 1: 0 = MANUAL, 1 = SCAN.
- `ch_en`, in, `CHANNELS`: scan enable mask; bit *i* enables channel *i*. Ignored in MANUAL.
- `out`, out, `WIDTH`: registered selected data.
- `out_ch`, out, `SEL_W`: registered index of the channel driving `out`.
- `out_valid`, out, 1: registered; 1 when `out` holds real channel data.

## Operation
Sequential state:
- Scan pointer `ptr` (`SEL_W` bits).
- Dwell counter `cnt` (`$clog2(DWELL+1)` bits).
- Output registers `out`, `out_ch`, `out_valid`.

Operating modes, selected directly by `mode` each cycle:
- **MANUAL**
  - Selected channel is `sel`.
  - If `sel` < `CHANNELS`: `out <= in[sel]`, `out_ch <= sel`, `out_valid <= 1`.
  - If `sel` ≥ `CHANNELS` (possible only when `CHANNELS` is not a power of 2): `out <= 0`, `out_ch <= sel`, `out_valid <= 0`.
  - `ptr <= 0` and `cnt <= 0` every MANUAL cycle, so every entry into SCAN starts at channel 0.
- **SCAN**
  - Selected channel is `ptr`.
  - If `ch_en[ptr]` = 1:
    - `out <= in[ptr]`, `out_ch <= ptr`, `out_valid <= 1`.
    - If `cnt` = `DWELL-1`: advance `ptr`, `cnt <= 0`.
    - Otherwise: `cnt <= cnt+1`.
  - If `ch_en[ptr]` = 0 (includes a mask change mid-dwell):
    - `out <= 0`, `out_ch <= ptr`, `out_valid <= 0`.
    - Advance `ptr` immediately, `cnt <= 0`.
  - Advance rule: `ptr` becomes the next enabled channel strictly after `ptr`, searching circularly and wrapping `CHANNELS-1`→0.
    - If `ptr` is the only enabled channel, it is re-selected.
    - If `ch_en` is all zero, `ptr` holds, `cnt` stays 0 and `out_valid` stays 0.
- `in`, `sel` and `ch_en` are sampled on the same edge as the output update; there are no input registers.

## Timing
- Reset (`rst_n` low, asynchronous, any time including mid-dwell):
  - `out`=0, `out_ch`=0, `out_valid`=0, `ptr`=0, `cnt`=0.
  - First update occurs on the first rising edge after deassertion.
- Latency: one cycle. Values present before edge *k* appear on the outputs after edge *k*.
- Dwell: in SCAN with a stable mask, each enabled channel appears on `out_ch` for exactly `DWELL` consecutive cycles. With `DWELL`=1 the channel changes every cycle.
- Disabled channel at `ptr`: costs exactly one `out_valid`=0 cycle, then the next enabled channel begins a full dwell.
- Mode switch:
  - SCAN→MANUAL: `sel` takes effect at the next edge.
  - MANUAL→SCAN: the first SCAN edge uses `ptr`=0.

## Structure
- Shared package/header holds:
  - Mode constants `MODE_MANUAL`=1'b0 and `MODE_SCAN`=1'b1.
  - Default parameter values.
- One sub-module, `next_en_finder`: combinational circular priority search.
  - Inputs: `ch_en`, `ptr`.
  - Outputs: next index and a `found` flag.
  - Parametrised by `CHANNELS`.
- Top level holds the counter, pointer and output registers.

## Test plan
Unless noted, `CHANNELS`=8, `WIDTH`=4, `DWELL`=3, and channel *i* data = 4'h*i*+1.
1. **Reset:** `mode`=1, `ch_en`=8'hFF; pull `rst_n` low mid-dwell between edges → `out`, `out_ch` and `out_valid` go to 0 immediately, without a clock edge. After release, `out_ch` sequence is 0,0,0,1.
2. **Manual:** `mode`=0, `sel`=5 → after the next edge `out`=4'h6, `out_ch`=5, `out_valid`=1. Then `sel`=2 → `out`=4'h3 exactly one edge later.
3. **Full scan:** `ch_en`=8'hFF, `mode` 0→1 → `out_ch` over successive edges is 0,0,0,1,1,1,…,7,7,7,0,0,0, with `out_valid`=1 throughout.
4. **Masked scan:** `ch_en`=8'h82 → first edge `out_valid`=0 (channel 0 disabled), then `out_ch` is 1,1,1,7,7,7,1,1,1.
5. **Empty mask:** `ch_en`=0 in SCAN → `out_valid`=0 and `out`=0 on every edge.
   - Then set `ch_en`=8'h08 → exactly one more invalid edge, then `out_ch`=3 with `out`=4'h4 for 3 edges, repeating.
6. **Out-of-range select:** `CHANNELS`=6, `mode`=0, `sel`=3'd6 → `out`=0, `out_valid`=0. Then `sel`=3'd5 → `out_valid`=1, `out`=4'h6.

Source files
------------

// File: rtl/scan_mux_pkg.sv
// Shared constants for the scan_mux channel multiplexer.
package scan_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int DEF_WIDTH    = 1;
  localparam int DEF_CHANNELS = 8;
  localparam int DEF_DWELL    = 4;

endpackage

// File: rtl/scan_mux_next_en_finder.sv
// Circular priority search: next enabled channel strictly after ptr, wrapping to ptr itself.
module next_en_finder #(
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] ch_en,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    nxt,
  output logic                found
);

  always_comb begin
    logic hit;
    int   idx;
    hit   = 1'b0;
    idx   = 0;
    nxt   = ptr;
    found = |ch_en;
    // k = CHANNELS lands back on ptr, so a lone enabled channel re-selects itself.
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = (int'(ptr) + k) % CHANNELS;
      if (!hit && ch_en[idx]) begin
        nxt = SEL_W'(idx);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_mux.sv
// Registered N-to-1 channel mux with a manual select and a masked auto-scan mode.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int DWELL    = DEF_DWELL
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CHANNELS*WIDTH-1:0]   in,
  input  logic [$clog2(CHANNELS)-1:0] sel,
  input  logic                        mode,
  input  logic [CHANNELS-1:0]         ch_en,
  output logic [WIDTH-1:0]            out,
  output logic [$clog2(CHANNELS)-1:0] out_ch,
  output logic                        out_valid
);

  localparam int SEL_W = $clog2(CHANNELS);
  localparam int NPAD  = 2 ** SEL_W;
  localparam int CNT_W = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;

  logic [SEL_W-1:0] nxt;
  logic             found;

  // Pad to a full power-of-two table so any SEL_W index is in range; unused slots read as 0.
  logic [NPAD-1:0]  en_pad;
  logic [WIDTH-1:0] in_arr [NPAD];

  assign en_pad = NPAD'(ch_en);

  for (genvar i = 0; i < NPAD; i++) begin : g_ch
    if (i < CHANNELS) begin : g_real
      assign in_arr[i] = in[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign in_arr[i] = '0;
    end
  end

  next_en_finder #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_finder (
    .ch_en (ch_en),
    .ptr   (ptr_q),
    .nxt   (nxt),
    .found (found)
  );

  always_comb begin
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    out_d       = '0;
    out_ch_d    = ptr_q;
    out_valid_d = 1'b0;
    if (mode == MODE_MANUAL) begin
      ptr_d    = '0;
      cnt_d    = '0;
      out_ch_d = sel;
      if (int'(sel) < CHANNELS) begin
        out_d       = in_arr[sel];
        out_valid_d = 1'b1;
      end
    end else if (en_pad[ptr_q]) begin
      out_d       = in_arr[ptr_q];
      out_valid_d = 1'b1;
      if (cnt_q == CNT_LAST) begin
        ptr_d = nxt;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      // Disabled channel: spend one invalid cycle and move on; empty mask holds ptr.
      cnt_d = '0;
      if (found) ptr_d = nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_scan_mux;

  localparam int CH = 8;
  localparam int W  = 4;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    dat [CH];
  logic [CH*W-1:0] in_bus;
  logic [2:0]    sel;
  logic          mode;
  logic [CH-1:0] ch_en;
  logic [W-1:0]  out;
  logic [2:0]    out_ch;
  logic          out_valid;

  logic [2:0]    sel6;
  logic [W-1:0]  out6;
  logic [2:0]    out_ch6;
  logic          out_valid6;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  int m_ptr = 0;
  int m_dw  = 0;
  logic [W-1:0] e_out;
  int           e_ch;
  logic         e_valid;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < CH; i++) in_bus[i*W +: W] = dat[i];
  end

  scan_mux #(.WIDTH(W), .CHANNELS(CH), .DWELL(DW)) u_dut (
    .clk(clk), .rst_n(rst_n), .in(in_bus), .sel(sel), .mode(mode), .ch_en(ch_en),
    .out(out), .out_ch(out_ch), .out_valid(out_valid)
  );

  scan_mux #(.WIDTH(W), .CHANNELS(6), .DWELL(DW)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .in(in_bus[6*W-1:0]), .sel(sel6), .mode(1'b0), .ch_en(6'd0),
    .out(out6), .out_ch(out_ch6), .out_valid(out_valid6)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int next_enabled(input int p, input logic [CH-1:0] en);
    for (int k = 1; k <= CH; k++)
      if (en[(p + k) % CH]) return (p + k) % CH;
    return p;
  endfunction

  // Predict the outputs for the coming edge from the inputs held right now.
  task automatic model_step();
    if (mode == 1'b0) begin
      e_ch    = int'(sel);
      e_valid = 1'b1;
      e_out   = dat[sel];
      m_ptr   = 0;
      m_dw    = 0;
    end else if (ch_en[m_ptr]) begin
      e_ch    = m_ptr;
      e_valid = 1'b1;
      e_out   = dat[m_ptr];
      m_dw++;
      if (m_dw == DW) begin
        m_dw  = 0;
        m_ptr = next_enabled(m_ptr, ch_en);
      end
    end else begin
      e_ch    = m_ptr;
      e_valid = 1'b0;
      e_out   = '0;
      m_dw    = 0;
      m_ptr   = next_enabled(m_ptr, ch_en);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("model_out", 32'(out), 32'(e_out));
    check("model_ch", 32'(out_ch), 32'(e_ch));
    check("model_valid", 32'(out_valid), 32'(e_valid));
  endtask

  task automatic set_plan_data();
    for (int i = 0; i < CH; i++) dat[i] = 4'(i + 1);
  endtask

  initial begin
    set_plan_data();
    rst_n = 1'b0;
    sel   = 3'd0;
    sel6  = 3'd0;
    mode  = 1'b0;
    ch_en = '0;
    #12;
    check("rst_out", 32'(out), 32'd0);
    check("rst_ch", 32'(out_ch), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;

    // manual select
    sel = 3'd5;
    tick();
    check("man5_out", 32'(out), 32'h6);
    check("man5_ch", 32'(out_ch), 32'd5);
    check("man5_valid", 32'(out_valid), 32'd1);
    sel = 3'd2;
    tick();
    check("man2_out", 32'(out), 32'h3);

    // full scan
    ch_en = 8'hFF;
    mode  = 1'b1;
    for (int i = 0; i < 27; i++) begin
      tick();
      check("full_ch", 32'(out_ch), 32'((i / 3) % 8));
      check("full_valid", 32'(out_valid), 32'd1);
    end

    // asynchronous reset mid-dwell
    mode = 1'b0;
    tick();
    mode = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out", 32'(out), 32'd0);
    check("arst_ch", 32'(out_ch), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("arst_hold_valid", 32'(out_valid), 32'd0);
    #2;
    rst_n = 1'b1;
    m_ptr = 0;
    m_dw  = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("arst_seq", 32'(out_ch), (i < 3) ? 32'd0 : 32'd1);
    end

    // masked scan
    mode = 1'b0;
    tick();
    ch_en = 8'h82;
    mode  = 1'b1;
    tick();
    check("mask_first_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("mask_ch", 32'(out_ch), ((i / 3) == 1) ? 32'd7 : 32'd1);
      check("mask_valid", 32'(out_valid), 32'd1);
    end

    // empty mask, then a single channel
    mode = 1'b0;
    tick();
    ch_en = 8'h00;
    mode  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("empty_valid", 32'(out_valid), 32'd0);
      check("empty_out", 32'(out), 32'd0);
    end
    ch_en = 8'h08;
    tick();
    check("single_gap", 32'(out_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("single_ch", 32'(out_ch), 32'd3);
      check("single_out", 32'(out), 32'h4);
    end

    // out-of-range select on the 6-channel instance
    sel6 = 3'd6;
    @(posedge clk);
    #1;
    check("oor_out", 32'(out6), 32'd0);
    check("oor_valid", 32'(out_valid6), 32'd0);
    check("oor_ch", 32'(out_ch6), 32'd6);
    sel6 = 3'd5;
    @(posedge clk);
    #1;
    check("inr_valid", 32'(out_valid6), 32'd1);
    check("inr_out", 32'(out6), 32'h6);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < CH; c++) dat[c] = 4'($urandom_range(0, 15));
      sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 9) == 0) ch_en = 8'($urandom_range(0, 255));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
